reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Generates the staged, active-high reset lines that drive the `rst` pins of the async set/reset register primitives. Assertion is asynchronous. Deassertion is synchronized to `clk`, stretched, then released domain by domain in a fixed order. An optional software reset request reruns the release sequence without an external reset.

## Interface
- `SYNC_STAGES`, 3: synchronizer flops on the reset deassertion path; legal range ≥2.
- `STRETCH`, 16: cycles all outputs stay asserted after synchronization; legal range ≥1.
- `NUM_DOMAINS`, 3: number of staged reset outputs; legal range 1..8.
- `STAGGER`, 4: cycles between successive domain releases; legal range ≥1.
- `clk`  in  1  single clock.
- `rst`  in  1  external reset; asynchronous, active-low.
- `sw_req`  in  1  software reset request, synchronous to `clk`; present only with `RESET_SEQ_SWREQ_EN`.
- `rst_out`  out  NUM_DOMAINS  active-high reset per domain; bit 0 releases first.
- `busy`  out  1  high while any `rst_out` bit is asserted.
- `done`  out  1  high once every domain is released.

## Operation
- **Reset values** (any time `rst`=0): `rst_out` = all ones, `busy`=1, `done`=0, synchronizer cleared to 0, counters cleared to 0, FSM in HOLD. All of these take effect asynchronously, with no clock edge required.
- **FSM states:** HOLD, STRETCH, RELEASE, RUN.
- **HOLD:** the synchronizer shifts in a 1 per edge. When its last stage is 1, the FSM goes to STRETCH with the counter at 0.
- **STRETCH:** the counter increments each cycle. When it reaches `STRETCH`-1, the FSM goes to RELEASE, `rst_out[0]` clears, and the domain index is 1.
- **RELEASE:** the counter counts `STAGGER` cycles per step. At each step end, `rst_out[idx]` clears and idx increments. After the last bit clears, the FSM goes to RUN. With `NUM_DOMAINS`=1 the FSM passes directly to RUN.
- **RUN:** `done`=1, `busy`=0, and `rst_out` = all zeros.
- **Release ordering:** bits clear strictly in ascending index. A bit never reasserts except through external reset or a software request.
- **Counter width:** $clog2 of max(`STRETCH`,`STAGGER`)+1, unsigned. The counter is reloaded to 0 on every state or step change and never wraps inside a phase.
- **Reset mid-sequence:** asserting `rst` in any state aborts immediately and applies the reset values. The sequence restarts from HOLD on the next release of `rst`.
- **Glitch filtering:** a `rst` low pulse shorter than one cycle still forces full reassertion and a full resequence. No glitch filtering is performed.

## Timing
- Let edge 1 be the first `clk` posedge with `rst`=1.
- `rst_out[0]` falls after edge `SYNC_STAGES`+`STRETCH`.
- `rst_out[k]` falls after edge `SYNC_STAGES`+`STRETCH`+k·`STAGGER`.
- `done` rises, and `busy` falls, one edge after the last bit falls.
- With defaults: `rst_out[0]` falls after edge 19, `[1]` after edge 23, `[2]` after edge 27. `done`=1 and `busy`=0 after edge 28.
- All outputs come directly from flops. There is no combinational path from `rst` to outputs other than the async clear/set.

## Configuration
- **With `RESET_SEQ_SWREQ_EN` defined:** `sw_req` exists.
  - `sw_req`=1 sampled in RUN sets `rst_out` = all ones, `done`=0, `busy`=1 on the same edge, and enters STRETCH with the counter at 0.
  - The synchronizer is not re-run, so `rst_out[0]` falls `STRETCH` edges later, and the stagger follows as above.
  - `sw_req` in any state other than RUN is ignored and not queued. A level held high retriggers on each entry to RUN.
- **Without the macro:** the `sw_req` port and its logic are absent. The sequencer runs only after external reset.

## Test plan
- **Default release:** hold `rst`=0 for 5 cycles, then release. Require `rst_out` = 3'b111 through edge 19, 3'b110 after edge 19, 3'b100 after edge 23, 3'b000 after edge 27, and `done`=1 after edge 28.
- **Async assertion:** in RUN, drive `rst`=0 between clock edges. Require `rst_out`=3'b111, `done`=0, `busy`=1 before the next posedge.
- **Reset mid-sequence:** assert `rst`=0 at edge 21 (`rst_out`=3'b110), then release. Require the full 19/23/27 timing measured from the new release.
- **Software reset** (macro defined): pulse `sw_req` for 1 cycle in RUN. Require `rst_out`=3'b111 on that edge, then release at +16, +20, +24 edges, and `done` at +25.
- **Ignored request** (macro defined): pulse `sw_req` during STRETCH. Require timing identical to the default release.
- **Single domain:** `NUM_DOMAINS`=1, `SYNC_STAGES`=2, `STRETCH`=1. Require `rst_out` to fall after edge 3 and `done` to rise after edge 4.

Source files
------------

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: groups the reset sequencer's staged outputs and the
// optional software request into one bundle.
//   rst_out [NUM_DOMAINS]  active-high reset per domain, bit 0 releases first
//   busy                   high while any rst_out bit is asserted
//   done                   high once every domain is released
//   sw_req                 software reset request (RESET_SEQ_SWREQ_EN only)
// Modports: master = sequencer side, slave = consumer side.
interface reset_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 3
);
  logic [NUM_DOMAINS-1:0] rst_out;
  logic                   busy;
  logic                   done;
`ifdef RESET_SEQ_SWREQ_EN
  logic                   sw_req;

  modport master (input sw_req, output rst_out, busy, done);
  modport slave  (output sw_req, input rst_out, busy, done);
`else
  modport master (output rst_out, busy, done);
  modport slave  (input rst_out, busy, done);
`endif
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: produces staged active-high reset lines. Assertion is
// asynchronous; deassertion is synchronized to clk, stretched, then released
// one domain at a time in ascending index order.
// Ports:
//   clk   single clock
//   rst   external reset, asynchronous, active-low
//   bus   reset_sequencer_if.master (rst_out, busy, done, optional sw_req)
// Optional feature: define RESET_SEQ_SWREQ_EN to add sw_req, which reruns the
// stretch/release sequence when sampled high in RUN.
module reset_sequencer #(
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned STRETCH     = 16,
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned STAGGER     = 4
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.master bus
);
  localparam int unsigned MAX_CNT = (STRETCH > STAGGER) ? STRETCH : STAGGER;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned IDX_W   = $clog2(NUM_DOMAINS + 1);
  // The HOLD->STRETCH state register acts as the final synchronizer stage, so
  // only SYNC_STAGES-1 dedicated flops are needed to get SYNC_STAGES edges of
  // deassertion latency.
  localparam int unsigned SYNC_W  = SYNC_STAGES - 1;

  typedef enum logic [1:0] {
    S_HOLD,
    S_STRETCH,
    S_RELEASE,
    S_RUN
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_W-1:0]      sync_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q    <= '0;
      state_q   <= S_HOLD;
      cnt_q     <= '0;
      idx_q     <= '0;
      rst_out_q <= '1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      sync_q    <= (sync_q << 1) | SYNC_W'(1);
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rst_out_d = rst_out_q;
    busy_d    = busy_q;
    done_d    = done_q;
    case (state_q)
      S_HOLD: begin
        if (sync_q[SYNC_W-1]) begin
          state_d = S_STRETCH;
          cnt_d   = '0;
        end
      end
      S_STRETCH: begin
        if (cnt_q == CNT_W'(STRETCH - 1)) begin
          state_d      = S_RELEASE;
          cnt_d        = '0;
          idx_d        = IDX_W'(1);
          rst_out_d[0] = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: begin
        // Checking the index first gives the one-edge gap between the last
        // bit falling and done rising, including the single-domain case.
        if (idx_q == IDX_W'(NUM_DOMAINS)) begin
          state_d   = S_RUN;
          cnt_d     = '0;
          rst_out_d = '0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else if (cnt_q == CNT_W'(STAGGER - 1)) begin
          cnt_d     = '0;
          rst_out_d = rst_out_q & ~(NUM_DOMAINS'(1) << idx_q);
          idx_d     = idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RUN: begin
`ifdef RESET_SEQ_SWREQ_EN
        if (bus.sw_req) begin
          state_d   = S_STRETCH;
          cnt_d     = '0;
          idx_d     = '0;
          rst_out_d = '1;
          busy_d    = 1'b1;
          done_d    = 1'b0;
        end
`endif
      end
      default: state_d = S_HOLD;
    endcase
  end

  assign bus.rst_out = rst_out_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: two sequencers (default and single-domain) on a shared
// clock and reset, checked every cycle against a timing model that derives
// each output from the number of edges since the sequence origin, plus
// hand-computed pins at the key edges.
module tb_reset_sequencer;
  localparam int S0 = 3, T0 = 16, N0 = 3, G0 = 4;
  localparam int S1 = 2, T1 = 1,  N1 = 1, G1 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   swq0 = 1'b0;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reset_sequencer_if #(.NUM_DOMAINS(N0)) if0 ();
  reset_sequencer_if #(.NUM_DOMAINS(N1)) if1 ();

`ifdef RESET_SEQ_SWREQ_EN
  assign if0.sw_req = swq0;
  assign if1.sw_req = 1'b0;
`endif

  reset_sequencer #(.SYNC_STAGES(S0), .STRETCH(T0), .NUM_DOMAINS(N0), .STAGGER(G0)) u0 (
    .clk(clk), .rst(rst), .bus(if0)
  );
  reset_sequencer #(.SYNC_STAGES(S1), .STRETCH(T1), .NUM_DOMAINS(N1), .STAGGER(G1)) u1 (
    .clk(clk), .rst(rst), .bus(if1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: bit k is released once n reaches base + stretch + k*stagger edges;
  // done follows one edge after the last release. base is the synchronizer
  // latency after an external reset and 0 after a software request.
  function automatic logic [7:0] exp_rst(int n, int base, int stretch, int stagger, int nd);
    logic [7:0] r = '0;
    for (int k = 0; k < nd; k++)
      if (n < base + stretch + k * stagger) r[k] = 1'b1;
    return r;
  endfunction

  function automatic logic exp_done(int n, int base, int stretch, int stagger, int nd);
    return n >= base + stretch + (nd - 1) * stagger + 1;
  endfunction

  int n0 = 0, base0 = S0, n1 = 0, base1 = S1;
  logic sw_seen = 1'b0;

  always @(negedge rst) begin
    n0 = 0; base0 = S0; n1 = 0; base1 = S1;
  end

  always @(posedge clk) begin
    if (!rst) begin
      n0 = 0; base0 = S0; n1 = 0; base1 = S1;
    end else begin
`ifdef RESET_SEQ_SWREQ_EN
      sw_seen = swq0;
`endif
      if (sw_seen && exp_done(n0, base0, T0, G0, N0)) begin
        n0 = 0; base0 = 0;
      end else if (n0 < 1000) begin
        n0++;
      end
      if (n1 < 1000) n1++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic d0, d1;
      d0 = exp_done(n0, base0, T0, G0, N0);
      d1 = exp_done(n1, base1, T1, G1, N1);
      check("u0_rst_out", 32'(if0.rst_out), 32'(exp_rst(n0, base0, T0, G0, N0) & 8'h07));
      check("u0_done",    32'(if0.done), 32'(d0));
      check("u0_busy",    32'(if0.busy), 32'(!d0));
      check("u1_rst_out", 32'(if1.rst_out), 32'(exp_rst(n1, base1, T1, G1, N1) & 8'h01));
      check("u1_done",    32'(if1.done), 32'(d1));
      check("u1_busy",    32'(if1.busy), 32'(!d1));
    end
  end

  // Hand-computed pins for the default sequencer (edges after release or
  // after the software request edge) and for the single-domain sequencer.
  int         pin_ext[8] = '{1, 18, 19, 22, 23, 26, 27, 28};
  int         pin_sw[8]  = '{0, 15, 16, 19, 20, 23, 24, 25};
  logic [2:0] pin_ro[8]  = '{3'b111, 3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b000};
  logic       pin_dn[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  int         pin1_e[3]  = '{2, 3, 4};
  logic       pin1_ro[3] = '{1'b1, 1'b0, 1'b0};
  logic       pin1_dn[3] = '{1'b0, 1'b0, 1'b1};

  // Called at a negedge: releases rst and walks last_edge edges, checking
  // pins; optionally pulses sw_req so that it is sampled on edge sw_edge.
  task automatic release_walk(input int last_edge, input int sw_edge);
    #2 rst = 1'b1;
    for (int e = 1; e <= last_edge; e++) begin
      @(negedge clk);
      for (int i = 0; i < 8; i++)
        if (pin_ext[i] == e) begin
          check("pin_rst_out", 32'(if0.rst_out), 32'(pin_ro[i]));
          check("pin_done", 32'(if0.done), 32'(pin_dn[i]));
        end
      for (int i = 0; i < 3; i++)
        if (pin1_e[i] == e) begin
          check("pin1_rst_out", 32'(if1.rst_out), 32'(pin1_ro[i]));
          check("pin1_done", 32'(if1.done), 32'(pin1_dn[i]));
        end
      if (e == sw_edge - 1) #2 swq0 = 1'b1;
      if (e == sw_edge)     #2 swq0 = 1'b0;
    end
  endtask

  task automatic assert_reset(input int cycles);
    #2 rst = 1'b0;
    repeat (cycles) @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    // Default release after 5 cycles of reset.
    release_walk(30, 0);

    // Asynchronous assertion between edges while in RUN.
    #2 rst = 1'b0;
    #1;
    check("async_rst_out", 32'(if0.rst_out), 32'h7);
    check("async_done", 32'(if0.done), 32'h0);
    check("async_busy", 32'(if0.busy), 32'h1);
    check("async1_rst_out", 32'(if1.rst_out), 32'h1);
    repeat (3) @(negedge clk);

    // Abort mid-sequence at edge 21, then a full resequence.
    release_walk(21, 0);
    check("mid_rst_out", 32'(if0.rst_out), 32'h6);
    assert_reset(3);
    release_walk(30, 0);

    // Sub-cycle low glitch between edges still forces a full resequence.
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    #1 check("glitch_rst_out", 32'(if0.rst_out), 32'h7);
    @(negedge clk);
    assert_reset(2);
    release_walk(30, 0);

`ifdef RESET_SEQ_SWREQ_EN
    // Software request in RUN: all ones on that edge, then 16/20/24, done 25.
    #2 swq0 = 1'b1;
    for (int j = 0; j <= 26; j++) begin
      @(negedge clk);
      if (j == 0) begin
        check("sw_busy", 32'(if0.busy), 32'h1);
        #2 swq0 = 1'b0;
      end
      for (int i = 0; i < 8; i++)
        if (pin_sw[i] == j) begin
          check("sw_rst_out", 32'(if0.rst_out), 32'(pin_ro[i]));
          check("sw_done", 32'(if0.done), 32'(pin_dn[i]));
        end
    end

    // Request during STRETCH is ignored: default timing must hold.
    @(negedge clk);
    assert_reset(3);
    release_walk(30, 10);
`endif

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
